banked_memory: RTL



---
 rtl/banked_mem_pkg.sv | 26 ++
 rtl/banked_mem_rd_pipe.sv | 42 ++++
 rtl/banked_memory.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/banked_mem_pkg.sv
// Shared types and helpers for the banked memory block.
//   state_t   : clear-sequencer states (CLEAR sweeps storage to zero, IDLE serves the bus)
//   bus_op_t  : read operation captured on a bus edge
//   bank_bits : bit width needed to hold a bank number
//   window_hit: address decode for a 2^size_bits aligned window
package banked_mem_pkg;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_RD_MEM = 2'd1,
    OP_RD_REG = 2'd2
  } bus_op_t;

  function automatic int bank_bits(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  // Compares everything above the in-window offset bits.
  function automatic logic window_hit(input logic [31:0] addr, input logic [31:0] base,
                                      input int size_bits);
    return (addr >> size_bits) == (base >> size_bits);
  endfunction

endpackage

// File: rtl/banked_mem_rd_pipe.sv
// Read-return pipe: STAGES-deep valid/data shift line with synchronous flush.
//   clk, flush            : clock and synchronous flush (clears all valids and data_out)
//   issue_vld, issue_data : read captured on this edge
//   data_oe, data_out     : delivery STAGES cycles after issue; data_out holds between deliveries
module banked_mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              issue_vld,
  input  logic [DATA_W-1:0] issue_data,
  output logic              data_oe,
  output logic [DATA_W-1:0] data_out
);

  logic [STAGES-1:0] vld_p;
  logic [DATA_W-1:0] dat_p [STAGES];

  always_ff @(posedge clk) begin
    if (flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue_vld;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // Each stage only loads when a valid word moves into it, so the final
  // stage keeps the last delivered word while data_oe is low.
  always_ff @(posedge clk) begin
    if (issue_vld) dat_p[0] <= issue_data;
    for (int s = 1; s < STAGES; s++) begin
      if (vld_p[s-1]) dat_p[s] <= dat_p[s-1];
    end
    if (flush) dat_p[STAGES-1] <= '0;
  end

  assign data_oe  = vld_p[STAGES-1];
  assign data_out = dat_p[STAGES-1];

endmodule

// File: rtl/banked_memory.sv
// Bus-attached RAM with a bank-switched window.
// A 2^SIZE_BITS-word window at BASE_ADDR maps onto one of NUM_BANKS banks,
// selected by a register at BANK_REG_ADDR. After every reset a clear sweep
// zeroes all storage (busy=1) before the bus is served. Reads are pipelined
// with READ_LATENCY cycles from sample to data_oe.
// Ports:
//   clk, reset  : bus clock, synchronous active-high reset
//   addr        : bus address
//   data_in     : write data
//   rd, wr      : read / write strobes, sampled every posedge
//   data_out    : read data, meaningful while data_oe=1, otherwise holds
//   data_oe     : drive enable for the shared bus
//   busy        : clear sweep in progress
//   parity_err  : sticky parity error (only with BANKED_MEM_PARITY_EN)
// Build option: define BANKED_MEM_PARITY_EN to add per-word even parity.
module banked_memory
  import banked_mem_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter int                ADDR_W        = 16,
  parameter int                SIZE_BITS     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 16'h5000,
  parameter int                NUM_BANKS     = 4,
  parameter logic [ADDR_W-1:0] BANK_REG_ADDR = 16'h5FFF,
  parameter int                READ_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              busy
`ifdef BANKED_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int BANK_BITS = bank_bits(NUM_BANKS);
  localparam int IDX_W     = BANK_BITS + SIZE_BITS;
  localparam int DEPTH     = NUM_BANKS << SIZE_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
`ifdef BANKED_MEM_PARITY_EN
  localparam int PIPE_W = DATA_W + 1;
`else
  localparam int PIPE_W = DATA_W;
`endif

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     clr_idx;
  logic [BANK_BITS-1:0] bank;
  logic                 win_hit, reg_hit;
  logic [IDX_W-1:0]     bus_idx;
  bus_op_t              op;
  logic                 bank_we, mem_we;
  logic [IDX_W-1:0]     mem_widx;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem [DEPTH];
  logic [DATA_W-1:0]    rd_data;
  logic [PIPE_W-1:0]    pipe_din, pipe_dout;

  assign win_hit = window_hit(32'(addr), 32'(BASE_ADDR), SIZE_BITS);
  assign reg_hit = (addr == BANK_REG_ADDR);
  assign bus_idx = {bank, addr[SIZE_BITS-1:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_idx == LAST_IDX) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // The sweep owns the write port while clearing; bus strobes are dropped.
  // A write wins over a simultaneous read.
  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = bus_idx;
    mem_wdata = data_in;
    bank_we   = 1'b0;
    op        = OP_NONE;
    case (state)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_widx  = clr_idx;
        mem_wdata = '0;
      end
      IDLE: begin
        if (wr) begin
          mem_we  = win_hit;
          bank_we = reg_hit;
        end else if (rd) begin
          if (win_hit)      op = OP_RD_MEM;
          else if (reg_hit) op = OP_RD_REG;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                  clr_idx <= '0;
    else if (state == CLEAR)    clr_idx <= clr_idx + 1'b1;
  end

  // Upper data bits are discarded, so bank numbers wrap mod NUM_BANKS.
  always_ff @(posedge clk) begin
    if (reset)        bank <= '0;
    else if (bank_we) bank <= data_in[BANK_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  assign rd_data = (op == OP_RD_REG) ? DATA_W'(bank) : mem[bus_idx];

`ifdef BANKED_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_bad, par_flag_out, perr_q;

  always_ff @(posedge clk) begin
    if (mem_we) par_mem[mem_widx] <= ^mem_wdata;
  end

  // Mismatch is judged at issue and travels with the word; only memory
  // reads are checked.
  assign par_bad  = (op == OP_RD_MEM) && ((^mem[bus_idx]) != par_mem[bus_idx]);
  assign pipe_din = {par_bad, rd_data};
  assign data_out = pipe_dout[DATA_W-1:0];
  assign par_flag_out = pipe_dout[DATA_W];
  assign parity_err   = perr_q | (data_oe & par_flag_out);

  always_ff @(posedge clk) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= parity_err;
  end
`else
  assign pipe_din = rd_data;
  assign data_out = pipe_dout;
`endif

  // ---- read issue -> delivery pipe (READ_LATENCY stages) ----
  banked_mem_rd_pipe #(
    .DATA_W (PIPE_W),
    .STAGES (READ_LATENCY)
  ) u_rd_pipe (
    .clk        (clk),
    .flush      (reset),
    .issue_vld  (op != OP_NONE),
    .issue_data (pipe_din),
    .data_oe    (data_oe),
    .data_out   (pipe_dout)
  );

endmodule
